// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: optional boid update phase, then a raster sweep of (x, y) queries whose
// answers become framebuffer writes. Optional perf counters are enabled by BOID_WRITER_PERF_EN.
module boid_frame_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned QUERY_LAT  = 1,
    parameter int unsigned UPDATE_CYC = 64,
    parameter int unsigned ADDR_W     = 19,
    parameter logic [7:0]  BOID_COLOR = 8'hFF,
    parameter logic [7:0]  BG_COLOR   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              update_req,
    output logic              accel_en,
    output logic [31:0]       x_q,
    output logic [31:0]       y_q,
    input  logic              is_boid_here,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
`ifdef BOID_WRITER_PERF_EN
    ,
    output logic [31:0]       frame_cycles,
    output logic [15:0]       frame_count
`endif
);

    localparam int unsigned NPIX    = H_RES * V_RES;
    localparam int unsigned COL_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned CNT_MAX = (UPDATE_CYC > QUERY_LAT) ? UPDATE_CYC : QUERY_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   phase_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  pix_addr;
    logic [ADDR_W-1:0]  q_addr;
    logic               q_valid;
    logic               q_last;
    logic               issue;
    logic               accel_en_d;
    logic               busy_d;
    logic               done_d;
    logic [QUERY_LAT-1:0] v_pipe;
    logic [ADDR_W-1:0]  a_pipe [QUERY_LAT];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (update_req && (UPDATE_CYC != 0)) ? S_UPDATE : S_SCAN;
                end
            end
            S_UPDATE: begin
                if (phase_cnt == CNT_W'(UPDATE_CYC - 1)) begin
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (q_last) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (phase_cnt == CNT_W'(QUERY_LAT - 1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        issue      = (next_state == S_SCAN);
        accel_en_d = (next_state == S_UPDATE);
        busy_d     = (next_state == S_UPDATE) || (next_state == S_SCAN) || (next_state == S_DRAIN);
        done_d     = (next_state == S_DONE);
    end

    // Phase timer, restarted on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if ((next_state != state) || (state == S_IDLE)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    // Control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accel_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            accel_en <= accel_en_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Raster counters hold the next pixel to issue; the query registers hold the current one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            pix_addr <= '0;
            x_q      <= '0;
            y_q      <= '0;
            q_addr   <= '0;
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
        end else begin
            q_valid <= issue;
            q_last  <= issue && (pix_addr == ADDR_W'(NPIX - 1));
            if (issue) begin
                x_q      <= 32'(col) << FRAC_BITS;
                y_q      <= 32'(row) << FRAC_BITS;
                q_addr   <= pix_addr;
                pix_addr <= pix_addr + ADDR_W'(1);
                if (col == COL_W'(H_RES - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(V_RES - 1)) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end else if ((state == S_IDLE) || (state == S_DONE)) begin
                col      <= '0;
                row      <= '0;
                pix_addr <= '0;
            end
        end
    end

    // Address/valid delay matching the accelerator query latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_pipe <= '0;
            for (int i = 0; i < int'(QUERY_LAT); i++) begin
                a_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= q_valid;
            a_pipe[0] <= q_addr;
            for (int i = 1; i < int'(QUERY_LAT); i++) begin
                v_pipe[i] <= v_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
            end
        end
    end

    assign mem_we   = v_pipe[QUERY_LAT-1];
    assign mem_addr = a_pipe[QUERY_LAT-1];
    // Colour follows the answer arriving in the write cycle itself
    assign mem_wdata = mem_we ? (is_boid_here ? BOID_COLOR : BG_COLOR) : 8'h00;

`ifdef BOID_WRITER_PERF_EN
    logic [31:0] perf_cnt;

    // perf_cnt equals the cycle index since the accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt     <= '0;
            frame_cycles <= '0;
            frame_count  <= '0;
        end else begin
            if ((state == S_IDLE) && (next_state != S_IDLE)) begin
                perf_cnt <= 32'd1;
            end else if (busy) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (done_d) begin
                frame_cycles <= perf_cnt + 32'd1;
                frame_count  <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule
